// File: rtl/spi_pwm_ctrl.sv
// spi_pwm_ctrl: register bank and PWM sequencer between the SPI slave and the
// PWM outputs. SPI write strobes are synchronized into the clk domain and
// committed to a 16-entry address map. A prescaled period counter drives NCH
// double-buffered PWM channels.
// Optional feature macro: SPI_PWM_POLARITY_EN (adds POL register at 0x3 and
// per-channel output inversion).
module spi_pwm_ctrl #(
    parameter int          NCH    = 4,
    parameter logic [7:0]  ID_VAL = 8'h5A
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           spi_wr_en,
    input  logic [3:0]     spi_addr,
    input  logic [7:0]     spi_data,
    output logic [7:0]     rd_data,
    output logic [NCH-1:0] pwm_out,
    output logic           period_end
);

    // The CTRL.EN bit doubles as the sequencer state.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic sync3_q, sync3_d;
    logic commit;

    logic [7:0] presc_q, presc_d;
    logic [7:0] period_q, period_d;
    logic [NCH-1:0][7:0] duty_q, duty_d;
`ifdef SPI_PWM_POLARITY_EN
    logic [NCH-1:0] pol_q, pol_d;
`endif

    logic [7:0] period_sh_q, period_sh_d;
    logic [NCH-1:0][7:0] duty_sh_q, duty_sh_d;
    logic [7:0] presc_cnt_q, presc_cnt_d;
    logic [7:0] cnt_q, cnt_d;
    logic [NCH-1:0] pwm_q, pwm_d;
    logic period_end_q, period_end_d;
    logic tick;

    // Combinational read decode of the architectural registers (not shadows).
    always_comb begin
        rd_data = 8'h00;
        case (spi_addr)
            4'h0: rd_data = {7'b0000000, (state_q == RUN)};
            4'h1: rd_data = presc_q;
            4'h2: rd_data = period_q;
`ifdef SPI_PWM_POLARITY_EN
            4'h3: rd_data = 8'(pol_q);
`endif
            4'hF: rd_data = ID_VAL;
            default: rd_data = 8'h00;
        endcase
        for (int n = 0; n < NCH; n++) begin
            if (spi_addr == 4'(4 + n)) begin
                rd_data = duty_q[n];
            end
        end
    end

    // Strobe synchronizer with rising-edge detect; one commit per strobe pulse.
    always_comb begin
        sync1_d  = spi_wr_en;
        sync2_d  = sync1_q;
        sync3_d  = sync2_q;
        commit   = sync2_q & ~sync3_q;
        state_d  = state_q;
        presc_d  = presc_q;
        period_d = period_q;
        duty_d   = duty_q;
`ifdef SPI_PWM_POLARITY_EN
        pol_d    = pol_q;
`endif
        if (commit) begin
            case (spi_addr)
                4'h0: state_d  = spi_data[0] ? RUN : IDLE;
                4'h1: presc_d  = spi_data;
                4'h2: period_d = spi_data;
`ifdef SPI_PWM_POLARITY_EN
                4'h3: pol_d    = spi_data[NCH-1:0];
`endif
                default: ;
            endcase
            for (int n = 0; n < NCH; n++) begin
                if (spi_addr == 4'(4 + n)) begin
                    duty_d[n] = spi_data;
                end
            end
        end
    end

    // Prescaler, period counter, shadow loading and PWM compare.
    always_comb begin
        tick         = (presc_cnt_q == presc_q);
        presc_cnt_d  = presc_cnt_q;
        cnt_d        = cnt_q;
        period_sh_d  = period_sh_q;
        duty_sh_d    = duty_sh_q;
        period_end_d = 1'b0;
        for (int n = 0; n < NCH; n++) begin
            pwm_d[n] = (state_q == RUN) && (cnt_q < duty_sh_q[n]);
        end
`ifdef SPI_PWM_POLARITY_EN
        pwm_d = pwm_d ^ pol_q;
`endif
        if (state_q == IDLE) begin
            presc_cnt_d = 8'h00;
            cnt_d       = 8'h00;
            period_sh_d = period_q;
            duty_sh_d   = duty_q;
        end else if (tick) begin
            presc_cnt_d = 8'h00;
            if (cnt_q == period_sh_q) begin
                cnt_d        = 8'h00;
                period_end_d = 1'b1;
                period_sh_d  = period_q;
                duty_sh_d    = duty_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            presc_cnt_d = presc_cnt_q + 8'd1;
        end
    end

    // All state flops, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
            presc_q      <= 8'h00;
            period_q     <= 8'h00;
            duty_q       <= '0;
`ifdef SPI_PWM_POLARITY_EN
            pol_q        <= '0;
`endif
            period_sh_q  <= 8'h00;
            duty_sh_q    <= '0;
            presc_cnt_q  <= 8'h00;
            cnt_q        <= 8'h00;
            pwm_q        <= '0;
            period_end_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sync3_q      <= sync3_d;
            presc_q      <= presc_d;
            period_q     <= period_d;
            duty_q       <= duty_d;
`ifdef SPI_PWM_POLARITY_EN
            pol_q        <= pol_d;
`endif
            period_sh_q  <= period_sh_d;
            duty_sh_q    <= duty_sh_d;
            presc_cnt_q  <= presc_cnt_d;
            cnt_q        <= cnt_d;
            pwm_q        <= pwm_d;
            period_end_q <= period_end_d;
        end
    end

    assign pwm_out    = pwm_q;
    assign period_end = period_end_q;

endmodule
